// File: rtl/pc_fetch_sequencer_if.sv
// Fetch-side bus: single-outstanding instruction memory request/ack plus the
// valid/ready hand-off of fetched instructions to decode.
interface pc_fetch_sequencer_if #(
  parameter int PC_WIDTH = 32
);
  logic                imem_req;
  logic [PC_WIDTH-1:0] imem_addr;
  logic                imem_ack;
  logic [31:0]         imem_rdata;
  logic                instr_valid;
  logic [31:0]         instr;
  logic [PC_WIDTH-1:0] instr_pc;
  logic                instr_ready;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// Program counter owner and fetch sequencer: next-PC select (seq/branch/jump/
// return), single-outstanding imem handshake, decode hand-off, wrong-path squash.
module pc_fetch_sequencer #(
  parameter int                  PC_WIDTH  = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
  parameter int                  RAS_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic                halt,
  input  logic                br_taken,
  input  logic [PC_WIDTH-1:0] br_base,
  input  logic [PC_WIDTH-1:0] sign_imm,
  input  logic                jmp_valid,
  input  logic                jmp_link,
  input  logic [PC_WIDTH-1:0] jmp_target,
  input  logic                ret_valid,
  output logic                ras_underflow,
  output logic                busy,
  pc_fetch_sequencer_if.master bus
);

  localparam int RAS_AW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam logic [RAS_AW:0] RAS_FULL = (RAS_AW+1)'(RAS_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DELIVER} state_t;

  state_t              r_state, w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [PC_WIDTH-1:0] r_addr;
  logic [PC_WIDTH-1:0] w_target;
  logic                r_squash, w_squash_nxt;
  logic                r_instr_valid, w_valid_nxt;
  logic                w_load_instr;
  logic [31:0]         r_instr;
  logic [PC_WIDTH-1:0] r_instr_pc;
  logic                r_underflow;

  logic [PC_WIDTH-1:0] r_ras_mem [RAS_DEPTH];
  logic [RAS_AW-1:0]   r_ras_wp;
  logic [RAS_AW-1:0]   w_ras_top;
  logic [RAS_AW:0]     r_ras_cnt;

  logic w_redir, w_push, w_pop, w_ras_empty, w_ack;

  // Redirect priority: branch beats jump beats return; losers have no side effects.
  assign w_redir     = br_taken | jmp_valid | ret_valid;
  assign w_push      = ~br_taken & jmp_valid & jmp_link;
  assign w_pop       = ~br_taken & ~jmp_valid & ret_valid;
  assign w_ras_empty = (r_ras_cnt == '0);
  assign w_ras_top   = r_ras_wp - RAS_AW'(1);
  assign w_ack       = (r_state == S_FETCH) & bus.imem_ack;

  always_comb begin
    w_target = RESET_PC;
    if (br_taken)          w_target = br_base + sign_imm;
    else if (jmp_valid)    w_target = jmp_target;
    else if (!w_ras_empty) w_target = r_ras_mem[w_ras_top];
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_squash_nxt = r_squash;
    w_valid_nxt  = r_instr_valid;
    w_load_instr = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (run && !halt) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (w_ack) begin
          if (r_squash || w_redir) begin
            // Wrong-path data: drop it and re-request from the (new) pc.
            w_squash_nxt = 1'b0;
            if (halt) w_state_nxt = S_IDLE;
          end else begin
            w_load_instr = 1'b1;
            w_valid_nxt  = 1'b1;
            w_pc_nxt     = r_pc + PC_WIDTH'(1);
            w_state_nxt  = S_DELIVER;
          end
        end else if (w_redir) begin
          w_squash_nxt = 1'b1;
        end
      end
      S_DELIVER: begin
        if (w_redir || bus.instr_ready) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = halt ? S_IDLE : S_FETCH;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_redir) w_pc_nxt = w_target;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_pc          <= RESET_PC;
      r_addr        <= RESET_PC;
      r_squash      <= 1'b0;
      r_instr_valid <= 1'b0;
      r_instr       <= '0;
      r_instr_pc    <= '0;
      r_underflow   <= 1'b0;
      r_ras_wp      <= '0;
      r_ras_cnt     <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_squash      <= w_squash_nxt;
      r_instr_valid <= w_valid_nxt;
      r_underflow   <= w_pop & w_ras_empty;
      // Address is frozen while a request is outstanding, even across a redirect.
      if (!(r_state == S_FETCH && !bus.imem_ack)) r_addr <= w_pc_nxt;
      if (w_load_instr) begin
        r_instr    <= bus.imem_rdata;
        r_instr_pc <= r_pc;
      end
      if (w_push) begin
        r_ras_wp <= r_ras_wp + RAS_AW'(1);
        if (r_ras_cnt != RAS_FULL) r_ras_cnt <= r_ras_cnt + (RAS_AW+1)'(1);
      end else if (w_pop && !w_ras_empty) begin
        r_ras_wp  <= w_ras_top;
        r_ras_cnt <= r_ras_cnt - (RAS_AW+1)'(1);
      end
    end
  end

  // Full stack wraps the write pointer onto the oldest entry.
  always_ff @(posedge clk) begin
    if (w_push) r_ras_mem[r_ras_wp] <= br_base;
  end

  assign bus.imem_req    = (r_state == S_FETCH);
  assign bus.imem_addr   = r_addr;
  assign bus.instr_valid = r_instr_valid;
  assign bus.instr       = r_instr;
  assign bus.instr_pc    = r_instr_pc;
  assign ras_underflow   = r_underflow;
  assign busy            = (r_state != S_IDLE);

endmodule

// File: doc/pc_fetch_sequencer.md
Name: pc_fetch_sequencer

Overview:
Owns the program counter and sequences instruction fetch for the processor core. Each cycle it selects the next PC from sequential (PC+1), branch (PC+1 + sign-extended immediate), jump, or return-stack sources. It runs a single-outstanding request/ack handshake to instruction memory and presents fetched instructions to decode with a valid/ready handshake. Wrong-path fetches are squashed on redirect.

Parameters:
PC_WIDTH, 32, width of PC, memory address and immediate (word-addressed; +1 = next instruction)
RESET_PC, 0, PC value loaded on reset and used on return-stack underflow
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
run  in  1  level; start/continue fetching
halt  in  1  level; stop fetching after the outstanding transaction completes
imem_req  out  1  fetch request, held until imem_ack
imem_addr  out  PC_WIDTH  fetch address, stable while imem_req=1
imem_ack  in  1  one-cycle pulse; imem_rdata valid this cycle
imem_rdata  in  32  fetched instruction
instr_valid  out  1  instr/instr_pc valid for decode
instr  out  32  fetched instruction
instr_pc  out  PC_WIDTH  address of instr
instr_ready  in  1  decode accepts instr this cycle
br_taken  in  1  branch resolved taken
br_base  in  PC_WIDTH  PC+1 of the redirecting branch/jump instruction
sign_imm  in  PC_WIDTH  sign-extended branch offset
jmp_valid  in  1  unconditional jump
jmp_link  in  1  with jmp_valid: push br_base onto the return-address stack (RAS)
jmp_target  in  PC_WIDTH  jump destination
ret_valid  in  1  return; target = RAS top, pop
ras_underflow  out  1  one-cycle pulse on pop of an empty RAS
busy  out  1  high when state != IDLE

Behaviour:
- Reset (async, reset_n=0): pc=RESET_PC; state=IDLE; imem_req=0; imem_addr=RESET_PC; instr_valid=0; instr=0; instr_pc=0; RAS empty; squash=0; ras_underflow=0; busy=0.
- States: IDLE, FETCH, DELIVER.
- IDLE: imem_req=0. If run=1 and halt=0, go to FETCH next cycle.
- FETCH:
  - imem_req=1 and imem_addr=pc, both held until imem_ack.
  - On ack with squash=0: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+1, go to DELIVER.
  - On ack with squash=1: discard the data, clear squash, stay in FETCH and request the new pc next cycle.
- DELIVER:
  - instr_valid held with stable data until instr_ready=1.
  - On acceptance: if halt=1, go to IDLE; otherwise go to FETCH next cycle.
  - Throughput: at most one instruction per 2 cycles with a zero-wait memory.
- Redirect: a cycle with br_taken | jmp_valid | ret_valid.
  - Priority: br_taken > jmp_valid > ret_valid. Lower-priority requests in the same cycle are ignored, with no push or pop.
  - Targets, all modulo 2^PC_WIDTH (wrap, no error):
    - branch: br_base + sign_imm
    - jump: jmp_target
    - return: RAS top
  - Effect: pc<=target next cycle.
  - In DELIVER: instr_valid<=0 and the held instruction is dropped even if instr_ready=1 the same cycle. Go to FETCH, or to IDLE if halt=1.
  - In FETCH with the request pending and no ack this cycle: imem_req stays high and the address stays unchanged (no abort), squash<=1.
  - In FETCH with ack in the same cycle: the data is discarded and the next request uses the target.
  - In IDLE: pc is updated; no fetch starts.
- RAS:
  - Circular buffer with a count.
  - Push (jmp_valid & jmp_link, winning priority): write br_base. When full, overwrite the oldest entry; count saturates at RAS_DEPTH.
  - Pop on empty: target=RESET_PC, ras_underflow=1 for one cycle.
- Halt: sampled in DELIVER on acceptance or redirect, and in FETCH only after the outstanding ack. pc is retained. run=1 with halt=0 resumes from the retained pc.
- Reset mid-transaction: all state is cleared immediately. The memory must tolerate imem_req dropping without an ack.

Test Plan:
- Reset then run=1, zero-wait ack, instr_ready=1 always -> imem_addr sequence 0,1,2,3; instr_pc matches; instr_valid pulses every 2nd cycle.
- imem_ack delayed 3 cycles -> imem_req and imem_addr=5 held stable across all 3 cycles; no instr_valid until the ack.
- br_taken with br_base=0x10, sign_imm=0xFFFFFFFC while a request to 0x11 is pending -> the 0x11 data is discarded, the next fetch is at 0x0C, and the wrong-path instruction never becomes valid.
- br_taken, jmp_valid and ret_valid in the same cycle -> branch target used; RAS count unchanged.
- 5 linked jumps (br_base=1..5) then 5 returns, RAS_DEPTH=4 -> return targets 5,4,3,2; the 5th return goes to RESET_PC with one ras_underflow pulse.
- halt=1 during a pending fetch -> ack delivered, instruction accepted, then IDLE with pc retained; run resumes at pc+1.
